// File: rtl/adc_capture_pkg.sv
// Shared types and constants for the ADC capture block.
package adc_capture_pkg;

    localparam int DW_DEFAULT = 14;

    localparam logic SLOPE_RISE = 1'b0;
    localparam logic SLOPE_FALL = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FILL,
        ST_WAIT_TRIG,
        ST_POST,
        ST_DONE
    } cap_state_t;

endpackage

// File: rtl/adc_capture_ram.sv
// Simple dual-port sample buffer: one synchronous write port and one
// registered read port. Contents are not reset; only the read register is.
module capture_ram #(
    parameter int DW         = 14,
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] waddr,
    input  logic [DW-1:0]         wdata,
    input  logic [DEPTH_LOG2-1:0] raddr,
    output logic [DW-1:0]         rdata
);

    logic [DW-1:0] mem_q [2**DEPTH_LOG2];
    logic [DW-1:0] rdata_q;

    // Sample write port
    always_ff @(posedge clk) begin
        if (we) mem_q[waddr] <= wdata;
    end

    // Registered read port, cleared by reset
    always_ff @(posedge clk) begin
        if (!rst_n) rdata_q <= '0;
        else        rdata_q <= mem_q[raddr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/adc_capture.sv
// Triggered ADC window capture into a circular buffer.
// Optional running min/max outputs: define ADC_CAPTURE_MINMAX_EN.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | after reset, nothing stored, waiting for arm
// FILL      | storing pre-trigger history, triggers ignored
// WAIT_TRIG | storing continuously, watching level/slope or force_trig
// POST      | storing the remainder of the window after the trigger
// DONE      | window frozen and readable, waiting for re-arm
module adc_capture
    import adc_capture_pkg::*;
#(
    parameter int DW         = DW_DEFAULT,
    parameter int DEPTH_LOG2 = 10,
    parameter int PRETRIG    = 128
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DW-1:0]         AD_A,
    input  logic                  AD_OTR_A,
    output logic                  AD_CLK_A,
    input  logic                  arm,
    input  logic                  force_trig,
    input  logic [DW-1:0]         trig_level,
    input  logic                  trig_slope,
    input  logic [3:0]            decim,
    output logic                  busy,
    output logic                  done,
    output logic                  ovr,
    input  logic [DEPTH_LOG2-1:0] rd_idx,
    output logic [DW-1:0]         rd_data
`ifdef ADC_CAPTURE_MINMAX_EN
   ,output logic [DW-1:0]         min_val,
    output logic [DW-1:0]         max_val
`endif
);

    localparam int AW    = DEPTH_LOG2;
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [AW-1:0] PRE_LD  = AW'(PRETRIG);
    // The trigger store itself counts toward the post-trigger length.
    localparam logic [AW-1:0] POST_LD = AW'(DEPTH - PRETRIG - 1);

    cap_state_t    state_q, state_d;
    logic [DW-1:0] s0_q, s1_q, s1_d;
    logic          s0_otr_q;
    logic [3:0]    dc_q, dc_d, decim_q, decim_d;
    logic [AW-1:0] wp_q, wp_d, cnt_q, cnt_d, trig_ptr_q, trig_ptr_d;
    logic          ovr_q, ovr_d, force_pend_q, force_pend_d;

    logic busy_s, arm_ok, store, hit_rise, hit_fall, level_hit, trig;

    assign AD_CLK_A  = clk;
    assign busy_s    = (state_q == ST_FILL) || (state_q == ST_WAIT_TRIG) || (state_q == ST_POST);
    assign arm_ok    = arm && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign store     = busy_s && (dc_q == decim_q);
    assign hit_rise  = (s1_q < trig_level) && (s0_q >= trig_level);
    assign hit_fall  = (s1_q > trig_level) && (s0_q <= trig_level);
    assign level_hit = (trig_slope == SLOPE_FALL) ? hit_fall : hit_rise;
    assign trig      = (state_q == ST_WAIT_TRIG) && store && (level_hit || force_trig || force_pend_q);

    assign busy = busy_s;
    assign done = (state_q == ST_DONE);
    assign ovr  = ovr_q;

    // Next-state and datapath updates for the capture sequencer
    always_comb begin
        state_d      = state_q;
        s1_d         = s1_q;
        dc_d         = dc_q;
        decim_d      = decim_q;
        wp_d         = wp_q;
        cnt_d        = cnt_q;
        trig_ptr_d   = trig_ptr_q;
        ovr_d        = ovr_q;
        force_pend_d = force_pend_q;

        if (busy_s) dc_d = store ? 4'd0 : dc_q + 4'd1;
        if (store) begin
            wp_d = wp_q + 1'b1;
            s1_d = s0_q;
            if (s0_otr_q) ovr_d = 1'b1;
        end

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (arm) begin
                    state_d      = (PRETRIG == 0) ? ST_WAIT_TRIG : ST_FILL;
                    cnt_d        = PRE_LD;
                    dc_d         = 4'd0;
                    decim_d      = decim;
                    ovr_d        = 1'b0;
                    force_pend_d = 1'b0;
                end
            end
            ST_FILL: begin
                if (store) begin
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == AW'(1)) state_d = ST_WAIT_TRIG;
                end
            end
            ST_WAIT_TRIG: begin
                // A force pulse between decimated strobes is held until the next one.
                if (force_trig) force_pend_d = 1'b1;
                if (trig) begin
                    trig_ptr_d   = wp_q;
                    cnt_d        = POST_LD;
                    force_pend_d = 1'b0;
                    state_d      = (POST_LD == '0) ? ST_DONE : ST_POST;
                end
            end
            ST_POST: begin
                if (store) begin
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == AW'(1)) state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any capture in progress
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            s0_q         <= '0;
            s0_otr_q     <= 1'b0;
            s1_q         <= '0;
            dc_q         <= '0;
            decim_q      <= '0;
            wp_q         <= '0;
            cnt_q        <= '0;
            trig_ptr_q   <= '0;
            ovr_q        <= 1'b0;
            force_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            s0_q         <= AD_A;
            s0_otr_q     <= AD_OTR_A;
            s1_q         <= s1_d;
            dc_q         <= dc_d;
            decim_q      <= decim_d;
            wp_q         <= wp_d;
            cnt_q        <= cnt_d;
            trig_ptr_q   <= trig_ptr_d;
            ovr_q        <= ovr_d;
            force_pend_q <= force_pend_d;
        end
    end

`ifdef ADC_CAPTURE_MINMAX_EN
    logic [DW-1:0] min_q, min_d, max_q, max_d;

    // Running extremes over samples stored once the pre-trigger fill is over
    always_comb begin
        min_d = min_q;
        max_d = max_q;
        if (arm_ok) begin
            min_d = '1;
            max_d = '0;
        end else if (store && ((state_q == ST_WAIT_TRIG) || (state_q == ST_POST))) begin
            if (s0_q < min_q) min_d = s0_q;
            if (s0_q > max_q) max_d = s0_q;
        end
    end

    // Min/max registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            min_q <= '1;
            max_q <= '0;
        end else begin
            min_q <= min_d;
            max_q <= max_d;
        end
    end

    assign min_val = min_q;
    assign max_val = max_q;
`endif

    capture_ram #(
        .DW         (DW),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_ram (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (store),
        .waddr (wp_q),
        .wdata (s0_q),
        .raddr (trig_ptr_q - PRE_LD + rd_idx),
        .rdata (rd_data)
    );

endmodule

// File: tb/tb_adc_capture.sv
// Bench for adc_capture: drives ADC sample sequences, models the stored
// window from the list of sampled values, and checks reads and timing.
module tb_adc_capture;

    localparam int DEPTH = 1024;
    localparam int PRE   = 128;
    localparam int POSTN = DEPTH - PRE;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [13:0] AD_A = '0;
    logic        AD_OTR_A = 1'b0;
    logic        AD_CLK_A;
    logic        arm = 1'b0;
    logic        force_trig = 1'b0;
    logic [13:0] trig_level = '0;
    logic        trig_slope = 1'b0;
    logic [3:0]  decim = '0;
    logic        busy, done, ovr;
    logic [9:0]  rd_idx = '0;
    logic [13:0] rd_data;

    int vectors = 0;
    int errors  = 0;
    int adq[$];
    int win[DEPTH];
    int exp_cyc;
    int got_cyc;
    int ref_cyc;

    always #5 clk = ~clk;

    adc_capture dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .AD_A       (AD_A),
        .AD_OTR_A   (AD_OTR_A),
        .AD_CLK_A   (AD_CLK_A),
        .arm        (arm),
        .force_trig (force_trig),
        .trig_level (trig_level),
        .trig_slope (trig_slope),
        .decim      (decim),
        .busy       (busy),
        .done       (done),
        .ovr        (ovr),
        .rd_idx     (rd_idx),
        .rd_data    (rd_data)
    );

    // Window model: every (d+1)-th sampled value is stored; the trigger is the
    // first store after the pre-trigger history that crosses the level (or is
    // at/after the force pulse); the window runs PRE before to POSTN-1 after.
    task automatic build_model(input int d, input int lvl, input bit slope, input int force_at);
        int st[$];
        int tj;
        bit hit;
        st.delete();
        for (int k = d; k < adq.size(); k += d + 1) st.push_back(adq[k]);
        tj = -1;
        for (int j = PRE; j < st.size(); j++) begin
            if (slope) hit = (st[j-1] > lvl) && (st[j] <= lvl);
            else       hit = (st[j-1] < lvl) && (st[j] >= lvl);
            if (force_at >= 0 && (1 + d + j * (d + 1)) >= force_at) hit = 1'b1;
            if (hit) begin
                tj = j;
                break;
            end
        end
        if (tj < 0 || tj + POSTN - 1 >= st.size()) begin
            exp_cyc = -2;
            for (int i = 0; i < DEPTH; i++) win[i] = -1;
        end else begin
            exp_cyc = 1 + d + (tj + POSTN - 1) * (d + 1);
            for (int i = 0; i < DEPTH; i++) win[i] = st[tj - PRE + i];
        end
    endtask

    // Arms a capture with a linear sample sequence and runs until done,
    // optional abort, or the cycle budget. Edge m=0 is the arm edge.
    task automatic run_capture(input int start, input int step, input int d, input int lvl,
                               input bit slope, input int force_at, input int otr_at,
                               input int rearm_at, input int abort_at);
        @(negedge clk);
        adq.delete();
        arm        = 1'b1;
        decim      = 4'(d);
        trig_level = 14'(lvl);
        trig_slope = slope;
        AD_A       = 14'(start);
        adq.push_back(int'(AD_A));
        got_cyc = -1;
        for (int n = 0; n < 8000; n++) begin
            @(negedge clk);
            if (n == 0) begin
                vectors++;
                if (busy !== 1'b1) begin
                    errors++;
                    $display("FAIL busy_after_arm: got %b want 1", busy);
                end
            end
            if (abort_at >= 0 && n == abort_at) begin
                vectors++;
                if (busy !== 1'b0 || done !== 1'b0) begin
                    errors++;
                    $display("FAIL abort: busy=%b done=%b want 0 0", busy, done);
                end
                break;
            end
            if (done === 1'b1) begin
                got_cyc = n;
                break;
            end
            arm        = (n + 1 == rearm_at);
            force_trig = (n + 1 == force_at);
            AD_OTR_A   = (n + 1 == otr_at);
            rst_n      = !(n + 1 == abort_at);
            AD_A       = 14'(start + step * (n + 1));
            adq.push_back(int'(AD_A));
        end
        arm = 1'b0;
        force_trig = 1'b0;
        AD_OTR_A = 1'b0;
        rst_n = 1'b1;
        if (abort_at < 0) begin
            build_model(d, lvl, slope, force_at);
            vectors++;
            if (got_cyc !== exp_cyc) begin
                errors++;
                $display("FAIL done_timing: got cycle %0d want %0d", got_cyc, exp_cyc);
            end
        end
    endtask

    task automatic read_idx(input int idx, output int val);
        @(negedge clk);
        rd_idx = 10'(idx);
        @(negedge clk);
        val = int'(rd_data);
    endtask

    task automatic check_random_reads(input int count);
        int idx, v;
        for (int k = 0; k < count; k++) begin
            idx = $urandom_range(0, DEPTH - 1);
            read_idx(idx, v);
            vectors++;
            if (v !== win[idx]) begin
                errors++;
                $display("FAIL window_read[%0d]: got %0d want %0d", idx, v, win[idx]);
            end
        end
        vectors++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL done_held_during_reads: got %b want 1", done);
        end
    endtask

    task automatic check_idx(input int idx, input int want);
        int v;
        read_idx(idx, v);
        vectors++;
        if (v !== want) begin
            errors++;
            $display("FAIL read_const[%0d]: got %0d want %0d", idx, v, want);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        arm = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        vectors++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        vectors++;
        if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        vectors++;
        if (ovr !== 1'b0) begin errors++; $display("FAIL reset_ovr: got %b want 0", ovr); end
        vectors++;
        if (rd_data !== 14'd0) begin errors++; $display("FAIL reset_rd_data: got %0d want 0", rd_data); end
        rst_n = 1'b1;
    endtask

    task automatic test_ramp();
        run_capture(0, 1, 0, 500, 1'b0, -1, -1, -1, -1);
        ref_cyc = got_cyc;
        check_idx(0, 372);
        check_idx(128, 500);
        check_idx(1023, 1395);
        vectors++;
        if (ovr !== 1'b0) begin errors++; $display("FAIL ramp_ovr: got %b want 0", ovr); end
        check_random_reads(6);
    endtask

    task automatic test_falling();
        run_capture(2000, -1, 0, 1000, 1'b1, -1, -1, -1, -1);
        check_idx(128, 1000);
        check_idx(127, 1001);
        check_random_reads(6);
    endtask

    task automatic test_random_level();
        int start, step, lvl;
        start = $urandom_range(0, 200);
        step  = $urandom_range(1, 3);
        lvl   = $urandom_range(700, 3000);
        run_capture(start, step, 0, lvl, 1'b0, -1, -1, -1, -1);
        check_random_reads(8);
    endtask

    task automatic test_decim();
        int start, lvl, i, a, b;
        start = $urandom_range(0, 50);
        lvl   = $urandom_range(700, 2000);
        run_capture(start, 1, 3, lvl, 1'b0, -1, -1, -1, -1);
        for (int k = 0; k < 4; k++) begin
            i = $urandom_range(0, DEPTH - 2);
            read_idx(i, a);
            read_idx(i + 1, b);
            vectors++;
            if (b - a !== 4) begin
                errors++;
                $display("FAIL decim_step[%0d]: got %0d want 4", i, b - a);
            end
        end
        read_idx(PRE, a);
        read_idx(PRE - 1, b);
        vectors++;
        if (!(a >= lvl && b < lvl)) begin
            errors++;
            $display("FAIL decim_trigger: got pre=%0d trig=%0d want first store >= %0d", b, a, lvl);
        end
        check_random_reads(6);
    endtask

    task automatic test_force_ovr();
        int i, v;
        run_capture(100, 0, 0, 500, 1'b0, 300, 500, -1, -1);
        for (int k = 0; k < 6; k++) begin
            i = $urandom_range(0, DEPTH - 1);
            read_idx(i, v);
            vectors++;
            if (v !== 100) begin
                errors++;
                $display("FAIL forced_read[%0d]: got %0d want 100", i, v);
            end
        end
        vectors++;
        if (ovr !== 1'b1) begin errors++; $display("FAIL ovr_sticky: got %b want 1", ovr); end
        @(negedge clk);
        arm = 1'b1;
        @(negedge clk);
        arm = 1'b0;
        vectors++;
        if (ovr !== 1'b0) begin errors++; $display("FAIL ovr_cleared_on_arm: got %b want 0", ovr); end
        vectors++;
        if (done !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL rearm_state: busy=%b done=%b want 1 0", busy, done);
        end
    endtask

    task automatic test_abort();
        do_reset();
        run_capture(0, 1, 0, 500, 1'b0, -1, -1, -1, 800);
        @(negedge clk);
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL abort_stays_idle: busy=%b done=%b want 0 0", busy, done);
        end
    endtask

    task automatic test_arm_ignored();
        run_capture(0, 1, 0, 500, 1'b0, -1, -1, 60, -1);
        vectors++;
        if (got_cyc !== ref_cyc) begin
            errors++;
            $display("FAIL arm_in_fill_timing: got cycle %0d want %0d", got_cyc, ref_cyc);
        end
        check_idx(128, 500);
        check_random_reads(4);
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_falling();
        test_random_level();
        test_decim();
        test_force_ovr();
        test_abort();
        test_arm_ignored();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
